slice_serial_subtractor: RTL and testbench

- Multi-cycle 64-bit subtractor computing diff = a - b - bin, one SLICE_W-bit slice per clock, least-significant slice first.
- A registered borrow carries between slices.
- Serves as the subtract/compare companion to the datapath's carry-select adder in the 5-stage processor ALU, trading latency for area.
- Uses a start/busy/done handshake and produces ALU status flags alongside the result.

---
 rtl/slice_serial_subtractor.sv | 100 ++++++++++
 tb/tb_slice_serial_subtractor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/slice_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one SLICE_W-bit slice per clock,
// LSB slice first, with a start/busy/done handshake and ALU status flags.
module slice_serial_subtractor #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   opa, opb, wrk, res;
    logic               brw;
    logic [CW-1:0]      cnt;
    logic [SLICE_W:0]   sub;
    logic               last, accept;

    assign busy = (state == RUN);

    always_comb begin
        accept = start && (state == IDLE);
        last   = (cnt == CW'(NSLICE - 1));
        sub    = {1'b0, opa[cnt*SLICE_W +: SLICE_W]}
               - {1'b0, opb[cnt*SLICE_W +: SLICE_W]}
               - {{SLICE_W{1'b0}}, brw};
        // res is the working word with the slice being computed this cycle merged in,
        // so the final cycle can publish the complete result directly.
        res    = wrk;
        res[cnt*SLICE_W +: SLICE_W] = sub[SLICE_W-1:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (last)   state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa  <= '0;
            opb  <= '0;
            wrk  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opa <= a;
                opb <= b;
                brw <= bin;
                cnt <= '0;
                wrk <= '0;
            end else if (state == RUN) begin
                wrk <= res;
                brw <= sub[SLICE_W];
                if (last) begin
                    diff <= res;
                    bout <= sub[SLICE_W];
                    zero <= (res == '0);
                    neg  <= res[WIDTH-1];
                    ovf  <= (opa[WIDTH-1] != opb[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_slice_serial_subtractor.sv
// Self-checking bench for slice_serial_subtractor: directed table, random ops against
// an arithmetic reference, and handshake corner sequences.
module tb_slice_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, zero, neg, ovf;
    logic [63:0] diff;

    int npass = 0;
    int ntotal = 0;

    typedef struct {
        logic [63:0] d;
        logic        bo, z, n, o;
    } exp_t;

    typedef struct {
        logic [63:0] a, b;
        logic        bin;
        exp_t        e;
    } vec_t;

    slice_serial_subtractor #(.WIDTH(64), .SLICE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout),
        .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic c);
        exp_t        m;
        logic [64:0] r;
        r    = {1'b0, x} - {1'b0, y} - {64'd0, c};
        m.d  = r[63:0];
        m.bo = r[64];
        m.z  = (r[63:0] == 64'd0);
        m.n  = r[63];
        m.o  = (x[63] != y[63]) && (r[63] != x[63]);
        return m;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "_diff"}, diff, e.d);
        chk({tag, "_bout"}, bout, e.bo);
        chk({tag, "_zero"}, zero, e.z);
        chk({tag, "_neg"},  neg,  e.n);
        chk({tag, "_ovf"},  ovf,  e.o);
    endtask

    // Counts edges (continuing from already) until done is seen; expects done at edge 4.
    task automatic wait_done(input int already, input string tag);
        int n;
        bit got;
        n = already;
        got = 0;
        while (n < 12) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                got = 1;
                break;
            end
            if (n < 4) chk({tag, "_busy_run"}, busy, 1);
        end
        chk({tag, "_latency"}, got ? n : 99, 4);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    // Accepts one operation, scrambles the inputs afterwards, then checks timing and result.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb2, input logic tc,
                          input exp_t e, input string tag);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb2; bin = tc;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom);
        chk({tag, "_busy_e0"}, busy, 1);
        wait_done(0, tag);
        check_result(tag, e);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        vec_t vecs[8];
        exp_t e1, e2;
        logic [63:0] ra, rb;
        logic rc;
        bit sawdone;

        vecs[0] = '{a:64'd10, b:64'd3, bin:1'b0, e:'{d:64'd7, bo:1'b0, z:1'b0, n:1'b0, o:1'b0}};
        vecs[1] = '{a:64'd0, b:64'd1, bin:1'b0, e:'{d:64'hFFFF_FFFF_FFFF_FFFF, bo:1'b1, z:1'b0, n:1'b1, o:1'b0}};
        vecs[2] = '{a:64'h8000_0000_0000_0000, b:64'd1, bin:1'b0, e:'{d:64'h7FFF_FFFF_FFFF_FFFF, bo:1'b0, z:1'b0, n:1'b0, o:1'b1}};
        vecs[3] = '{a:64'h7FFF_FFFF_FFFF_FFFF, b:64'hFFFF_FFFF_FFFF_FFFF, bin:1'b0, e:'{d:64'h8000_0000_0000_0000, bo:1'b1, z:1'b0, n:1'b1, o:1'b1}};
        vecs[4] = '{a:64'h1234_5678_9ABC_DEF0, b:64'h1234_5678_9ABC_DEF0, bin:1'b0, e:'{d:64'd0, bo:1'b0, z:1'b1, n:1'b0, o:1'b0}};
        vecs[5] = '{a:64'h1234_5678_9ABC_DEF0, b:64'h1234_5678_9ABC_DEF0, bin:1'b1, e:'{d:64'hFFFF_FFFF_FFFF_FFFF, bo:1'b1, z:1'b0, n:1'b1, o:1'b0}};
        vecs[6] = '{a:64'h0001_0000_0000_0000, b:64'd1, bin:1'b0, e:'{d:64'h0000_FFFF_FFFF_FFFF, bo:1'b0, z:1'b0, n:1'b0, o:1'b0}};
        vecs[7] = '{a:64'd0, b:64'd0, bin:1'b1, e:'{d:64'hFFFF_FFFF_FFFF_FFFF, bo:1'b1, z:1'b0, n:1'b1, o:1'b0}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        check_result("rst", '{d:64'd0, bo:1'b0, z:1'b0, n:1'b0, o:1'b0});
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
            rc = 1'($urandom);
            run_op(ra, rb, rc, model(ra, rb, rc), $sformatf("rnd%0d", i));
        end

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        start = 1'b1; a = 64'd10; b = 64'd3; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 64'd100; b = 64'd1; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, "midstart");
        check_result("midstart", model(64'd10, 64'd3, 1'b0));
        @(posedge clk); #1;
        chk("midstart_no_requeue_busy", busy, 0);
        chk("midstart_no_requeue_done", done, 0);

        // start held through the done cycle: second op accepted with no bubble
        e1 = model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1);
        e2 = model(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0009, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 64'hDEAD_BEEF_0000_0001; b = 64'h0000_0000_FFFF_FFFF; bin = 1'b1;
        @(posedge clk); #1;
        a = 64'd5; b = 64'd9; bin = 1'b0;
        wait_done(0, "b2b_first");
        check_result("b2b_first", e1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        chk("b2b_diff_held", diff, e1.d);
        wait_done(0, "b2b_second");
        check_result("b2b_second", e2);

        // reset in the middle of RUN aborts with no done pulse
        run_op(64'd10, 64'd3, 1'b0, model(64'd10, 64'd3, 1'b0), "prerst");
        @(negedge clk);
        start = 1'b1; a = 64'd50; b = 64'd20; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        @(negedge clk);
        rst = 1'b0;
        sawdone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) sawdone = 1;
        end
        chk("abort_no_done", sawdone, 0);
        chk("abort_idle", busy, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
